// File: rtl/immediate_encoder.sv
`default_nettype none
// ============================================================================
//  Module   : immediate_encoder
//  Purpose  : Reverse immediate lookup. A 16-bit constant is captured on a
//             valid/ready accept. It is then compared against the fixed
//             8-entry immediate table, one entry per clock, in code order
//             0..7. The result is the 3-bit IMIN code that produces the
//             constant, or a miss if the constant is not encodable.
//             Completed hits and misses are counted in saturating counters.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk        in   1      rising-edge clock
//    rst        in   1      synchronous active-high reset
//    in_valid   in   1      in_value is presented
//    in_ready   out  1      encoder idle and able to accept (from state reg)
//    in_value   in   16     constant to encode
//    out_valid  out  1      result available, held until out_ready
//    out_ready  in   1      consumer accepts the result
//    out_code   out  3      matching IMIN code, 0 on miss
//    out_hit    out  1      constant is encodable
//    out_value  out  16     echo of the captured constant
//    hit_cnt    out  CNT_W  completed hits, saturating
//    miss_cnt   out  CNT_W  completed misses, saturating
// ============================================================================
module immediate_encoder #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      in_value,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2:0]       out_code,
    output logic             out_hit,
    output logic [15:0]      out_value,
    output logic [CNT_W-1:0] hit_cnt,
    output logic [CNT_W-1:0] miss_cnt
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEARCH = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam logic [2:0]       LAST_IDX = 3'd7;
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    // Fixed immediate table: code -> value produced by the decoder.
    function automatic logic [15:0] table_value(input logic [2:0] code);
        logic [15:0] value;
        case (code)
            3'd0:    value = 16'h0000;
            3'd1:    value = 16'h0001;
            3'd2:    value = 16'h0020;
            3'd3:    value = 16'h0040;
            3'd4:    value = 16'h0060;
            3'd5:    value = 16'hFFFF;
            3'd6:    value = 16'h0090;
            default: value = 16'h0009;
        endcase
        return value;
    endfunction

    state_t      state;
    state_t      state_next;
    logic [2:0]  idx;
    logic        match;
    logic        accept;
    logic        finish_hit;
    logic        finish_miss;
    logic        release_result;

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state and handshake decode
    // ------------------------------------------------------------------------
    always_comb begin
        state_next     = state;
        in_ready       = 1'b0;
        accept         = 1'b0;
        finish_hit     = 1'b0;
        finish_miss    = 1'b0;
        release_result = 1'b0;
        // The comparison always uses the captured copy, so in_value may
        // change freely once the search has started.
        match          = (table_value(idx) == out_value);

        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    accept     = 1'b1;
                    state_next = SEARCH;
                end
            end
            SEARCH: begin
                if (match) begin
                    finish_hit = 1'b1;
                    state_next = DONE;
                end else if (idx == LAST_IDX) begin
                    finish_miss = 1'b1;
                    state_next  = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    release_result = 1'b1;
                    state_next     = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Datapath: capture, search index, result and statistics registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            idx       <= 3'd0;
            out_value <= 16'h0000;
            out_valid <= 1'b0;
            out_code  <= 3'd0;
            out_hit   <= 1'b0;
            hit_cnt   <= {CNT_W{1'b0}};
            miss_cnt  <= {CNT_W{1'b0}};
        end else begin
            if (accept) begin
                out_value <= in_value;
                idx       <= 3'd0;
            end

            // No match and entries left: advance to the next table entry.
            if (state == SEARCH && !finish_hit && !finish_miss) begin
                idx <= idx + 3'd1;
            end

            if (finish_hit) begin
                out_code  <= idx;
                out_hit   <= 1'b1;
                out_valid <= 1'b1;
                if (hit_cnt != CNT_MAX) begin
                    hit_cnt <= hit_cnt + CNT_ONE;
                end
            end

            if (finish_miss) begin
                out_code  <= 3'd0;
                out_hit   <= 1'b0;
                out_valid <= 1'b1;
                if (miss_cnt != CNT_MAX) begin
                    miss_cnt <= miss_cnt + CNT_ONE;
                end
            end

            // Result stays stable in DONE until the consumer takes it.
            if (release_result) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_immediate_encoder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_immediate_encoder
//  Purpose  : Self-checking bench for immediate_encoder. Expected codes,
//             latencies and counter values come from a table-search model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_immediate_encoder;

    localparam int CNT_W   = 8;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [15:0]      in_value;
    logic             out_valid;
    logic             out_ready;
    logic [2:0]       out_code;
    logic             out_hit;
    logic [15:0]      out_value;
    logic [CNT_W-1:0] hit_cnt;
    logic [CNT_W-1:0] miss_cnt;

    int errors;
    int checks;
    int hits_m;
    int misses_m;

    logic [15:0] imm_table [8];

    immediate_encoder #(.CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_value  (in_value),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_code  (out_code),
        .out_hit   (out_hit),
        .out_value (out_value),
        .hit_cnt   (hit_cnt),
        .miss_cnt  (miss_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1);
    end

    // Reference: linear search of the table, first match wins.
    function automatic void ref_encode(input logic [15:0] v, output logic [2:0] code,
                                       output logic hit, output int lat);
        code = 3'd0;
        hit  = 1'b0;
        for (int k = 0; k < 8; k++) begin
            if (!hit && imm_table[k] == v) begin
                code = k[2:0];
                hit  = 1'b1;
            end
        end
        lat = hit ? int'(code) + 1 : 8;
    endfunction

    function automatic int sat(input int n);
        return (n > CNT_MAX) ? CNT_MAX : n;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Accept v, then count edges until out_valid (-1 on timeout).
    task automatic run_txn(input logic [15:0] v, output int lat);
        int guard;
        guard = 0;
        while (!in_ready && guard < 50) begin
            step();
            guard++;
        end
        in_valid = 1'b1;
        in_value = v;
        step();
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 20) begin
            step();
            lat++;
        end
        if (!out_valid) lat = -1;
    endtask

    task automatic finish_txn();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        hits_m   = 0;
        misses_m = 0;
    endtask

    task automatic test_reset();
        pulse_reset();
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        checks++; if (out_code !== 3'd0) begin errors++; $display("FAIL reset_out_code: got %0d expected 0", out_code); end
        checks++; if (out_hit !== 1'b0) begin errors++; $display("FAIL reset_out_hit: got %b expected 0", out_hit); end
        checks++; if (out_value !== 16'h0000) begin errors++; $display("FAIL reset_out_value: got %h expected 0000", out_value); end
        checks++; if (hit_cnt !== '0) begin errors++; $display("FAIL reset_hit_cnt: got %0d expected 0", hit_cnt); end
        checks++; if (miss_cnt !== '0) begin errors++; $display("FAIL reset_miss_cnt: got %0d expected 0", miss_cnt); end
    endtask

    task automatic test_code0();
        int lat;
        out_ready = 1'b1;
        run_txn(16'h0000, lat);
        hits_m++;
        checks++; if (lat !== 1) begin errors++; $display("FAIL code0_latency: got %0d expected 1", lat); end
        checks++; if (out_code !== 3'd0) begin errors++; $display("FAIL code0_code: got %0d expected 0", out_code); end
        checks++; if (out_hit !== 1'b1) begin errors++; $display("FAIL code0_hit: got %b expected 1", out_hit); end
        checks++; if (hit_cnt !== CNT_W'(hits_m)) begin errors++; $display("FAIL code0_hit_cnt: got %0d expected %0d", hit_cnt, hits_m); end
        step();
        out_ready = 1'b0;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL code0_in_ready: got %b expected 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL code0_valid_drop: got %b expected 0", out_valid); end
    endtask

    task automatic test_all_codes();
        int lat;
        int exp_lat;
        logic [2:0] exp_code;
        logic exp_hit;
        pulse_reset();
        for (int k = 0; k < 8; k++) begin
            ref_encode(imm_table[k], exp_code, exp_hit, exp_lat);
            run_txn(imm_table[k], lat);
            hits_m++;
            checks++; if (lat !== exp_lat) begin errors++; $display("FAIL sweep_latency[%0d]: got %0d expected %0d", k, lat, exp_lat); end
            checks++; if (out_code !== exp_code || out_hit !== 1'b1) begin errors++; $display("FAIL sweep_code[%0d]: got %0d/%b expected %0d/1", k, out_code, out_hit, exp_code); end
            finish_txn();
        end
        checks++; if (hit_cnt !== 8'd8) begin errors++; $display("FAIL sweep_hit_cnt: got %0d expected 8", hit_cnt); end
    endtask

    task automatic test_miss();
        int lat;
        run_txn(16'h1234, lat);
        misses_m++;
        checks++; if (lat !== 8) begin errors++; $display("FAIL miss_latency: got %0d expected 8", lat); end
        checks++; if (out_hit !== 1'b0 || out_code !== 3'd0) begin errors++; $display("FAIL miss_result: got %0d/%b expected 0/0", out_code, out_hit); end
        checks++; if (out_value !== 16'h1234) begin errors++; $display("FAIL miss_value: got %h expected 1234", out_value); end
        checks++; if (miss_cnt !== 8'd1) begin errors++; $display("FAIL miss_cnt: got %0d expected 1", miss_cnt); end
        finish_txn();
    endtask

    task automatic test_backpressure();
        int lat;
        run_txn(16'hFFFF, lat);
        hits_m++;
        checks++; if (lat !== 6) begin errors++; $display("FAIL bp_latency: got %0d expected 6", lat); end
        for (int c = 0; c < 5; c++) begin
            in_valid = 1'b1;
            in_value = 16'($urandom);
            step();
            checks++;
            if (out_valid !== 1'b1 || out_code !== 3'd5 || out_hit !== 1'b1 ||
                out_value !== 16'hFFFF || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold[%0d]: got v=%b code=%0d hit=%b val=%h rdy=%b expected 1/5/1/ffff/0",
                         c, out_valid, out_code, out_hit, out_value, in_ready);
            end
        end
        in_valid = 1'b0;
        finish_txn();
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL bp_release: got v=%b rdy=%b expected 0/1", out_valid, in_ready); end
        checks++; if (hit_cnt !== CNT_W'(sat(hits_m))) begin errors++; $display("FAIL bp_hit_cnt: got %0d expected %0d", hit_cnt, sat(hits_m)); end
    endtask

    task automatic test_random();
        int lat;
        int exp_lat;
        int stall;
        logic [2:0] exp_code;
        logic exp_hit;
        logic [15:0] v;
        for (int n = 0; n < 40; n++) begin
            v = ($urandom_range(0, 1) == 1) ? imm_table[$urandom_range(0, 7)] : 16'($urandom);
            stall = $urandom_range(0, 3);
            ref_encode(v, exp_code, exp_hit, exp_lat);
            run_txn(v, lat);
            if (exp_hit) hits_m++; else misses_m++;
            checks++;
            if (lat !== exp_lat || out_code !== exp_code || out_hit !== exp_hit || out_value !== v) begin
                errors++;
                $display("FAIL rand_result[%0d] %h: got lat=%0d code=%0d hit=%b val=%h expected %0d/%0d/%b/%h",
                         n, v, lat, out_code, out_hit, out_value, exp_lat, exp_code, exp_hit, v);
            end
            checks++;
            if (hit_cnt !== CNT_W'(sat(hits_m)) || miss_cnt !== CNT_W'(sat(misses_m))) begin
                errors++;
                $display("FAIL rand_counters[%0d]: got %0d/%0d expected %0d/%0d",
                         n, hit_cnt, miss_cnt, sat(hits_m), sat(misses_m));
            end
            for (int s = 0; s < stall; s++) step();
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL rand_hold[%0d]: got %b expected 1", n, out_valid); end
            finish_txn();
        end
    endtask

    task automatic test_reset_mid();
        int lat;
        in_valid = 1'b1;
        in_value = 16'h0090;
        step();
        in_valid = 1'b0;
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        hits_m   = 0;
        misses_m = 0;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_code !== 3'd0 || out_hit !== 1'b0 ||
            out_value !== 16'h0000 || hit_cnt !== '0 || miss_cnt !== '0) begin
            errors++;
            $display("FAIL midrst_state: got rdy=%b v=%b code=%0d hit=%b val=%h hc=%0d mc=%0d expected 1/0/0/0/0000/0/0",
                     in_ready, out_valid, out_code, out_hit, out_value, hit_cnt, miss_cnt);
        end
        step();
        checks++; if (out_valid !== 1'b0 || hit_cnt !== '0) begin errors++; $display("FAIL midrst_discard: got v=%b hc=%0d expected 0/0", out_valid, hit_cnt); end
        run_txn(16'h0090, lat);
        hits_m++;
        checks++; if (lat !== 7 || out_code !== 3'd6 || out_hit !== 1'b1) begin errors++; $display("FAIL midrst_rerun: got lat=%0d code=%0d hit=%b expected 7/6/1", lat, out_code, out_hit); end
        checks++; if (hit_cnt !== 8'd1) begin errors++; $display("FAIL midrst_hit_cnt: got %0d expected 1", hit_cnt); end
        finish_txn();
    endtask

    task automatic test_saturation();
        int lat;
        int exp_lat;
        logic [2:0] exp_code;
        logic exp_hit;
        logic [15:0] v;
        pulse_reset();
        for (int n = 0; n < 260; n++) begin
            do begin
                v = 16'($urandom);
                ref_encode(v, exp_code, exp_hit, exp_lat);
            end while (exp_hit);
            run_txn(v, lat);
            misses_m++;
            checks++; if (miss_cnt !== CNT_W'(sat(misses_m))) begin errors++; $display("FAIL sat_miss_cnt[%0d]: got %0d expected %0d", n, miss_cnt, sat(misses_m)); end
            finish_txn();
        end
        checks++; if (miss_cnt !== 8'd255) begin errors++; $display("FAIL sat_final: got %0d expected 255", miss_cnt); end
        checks++; if (hit_cnt !== 8'd0) begin errors++; $display("FAIL sat_hit_cnt: got %0d expected 0", hit_cnt); end
    endtask

    initial begin
        imm_table = '{16'h0000, 16'h0001, 16'h0020, 16'h0040,
                      16'h0060, 16'hFFFF, 16'h0090, 16'h0009};
        errors    = 0;
        checks    = 0;
        hits_m    = 0;
        misses_m  = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_value  = 16'h0000;
        out_ready = 1'b0;

        test_reset();
        test_code0();
        test_all_codes();
        test_miss();
        test_backpressure();
        test_random();
        test_reset_mid();
        test_saturation();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/immediate_encoder.md
# immediate_encoder

Reverse of the immediate decode path. Takes a 16-bit constant and searches the fixed 8-entry immediate table, one entry per clock. It returns the 3-bit IMIN code that produces the constant, or reports that the constant is not encodable. It sits in the instruction-build/assembler-assist path ahead of instruction memory, with valid/ready handshakes on both sides and saturating hit/miss statistics.

## Interface
- CNT_W, default 8: width of the HIT_CNT / MISS_CNT statistic counters.
- CLK  input  1  clock; all state updates on rising edge.
- RST  input  1  synchronous, active-high reset.
- IN_VALID  input  1  IN_VALUE is presented.
- IN_READY  output  1  encoder can accept a value; high only in IDLE.
- IN_VALUE  input  16  constant to encode.
- OUT_VALID  output  1  result is available; held until accepted.
- OUT_READY  input  1  consumer accepts the result.
- OUT_CODE  output  3  matching IMIN code; 0 on miss.
- OUT_HIT  output  1  1 if the constant is encodable.
- OUT_VALUE  output  16  echo of the captured IN_VALUE.
- HIT_CNT  output  CNT_W  number of completed hits; saturating.
- MISS_CNT  output  CNT_W  number of completed misses; saturating.

## Operation
- Immediate table, code to value, fixed:
  - 0 → 0x0000
  - 1 → 0x0001
  - 2 → 0x0020
  - 3 → 0x0040
  - 4 → 0x0060
  - 5 → 0xFFFF
  - 6 → 0x0090
  - 7 → 0x0009
- Entries are unique. Search order is 0 up to 7, and the first match ends the search.
- The FSM has three states: IDLE, SEARCH and DONE.
- IDLE:
  - IN_READY = 1.
  - When IN_VALID is high, capture IN_VALUE into OUT_VALUE, clear the index to 0, and go to SEARCH.
- SEARCH:
  - IN_READY = 0.
  - Each edge compares the captured value against table[idx].
  - On a match: OUT_CODE = idx, OUT_HIT = 1, go to DONE, and increment HIT_CNT.
  - No match with idx < 7: increment idx and stay in SEARCH.
  - No match with idx == 7: OUT_CODE = 0, OUT_HIT = 0, go to DONE, and increment MISS_CNT.
- DONE:
  - OUT_VALID = 1.
  - OUT_CODE, OUT_HIT and OUT_VALUE are held stable while OUT_READY is low.
  - When OUT_READY is high: go to IDLE and drop OUT_VALID on that edge.
- No bypass: a new input is accepted only in the cycle after the result handshake completes, when IDLE asserts IN_READY.
- IN_VALUE is ignored outside IDLE, and the captured value never changes mid-search.
- The counters increment exactly once per search, on the SEARCH→DONE edge. They saturate at 2^CNT_W−1 and never wrap.
- RST:
  - Forces IDLE and idx = 0.
  - Clears OUT_VALID, OUT_CODE, OUT_HIT, OUT_VALUE, HIT_CNT and MISS_CNT to 0.
  - A search or pending result interrupted by RST is discarded and no counter changes.
  - RST has priority over every handshake in the same cycle.

## Timing
- Reset values:
  - IN_READY = 1, since the block is in IDLE.
  - OUT_VALID = 0, OUT_CODE = 0, OUT_HIT = 0.
  - OUT_VALUE = 0x0000, HIT_CNT = 0, MISS_CNT = 0.
- Latency is counted as edges from the accept edge (IDLE, IN_VALID high) to the first edge after which OUT_VALID = 1:
  - hit on code k: k+1 edges, so 1 to 8;
  - miss: 8 edges.
- Minimum spacing between consecutive results: search latency + 1 (handshake edge) + 1 (IDLE accept edge).
- All outputs are registered, except IN_READY, which is decoded from the state register.

## Test plan
- **Code 0 hit.** After RST, present 0x0000 with OUT_READY = 1.
  - Expect OUT_VALID 1 edge after accept, with OUT_CODE = 0, OUT_HIT = 1.
  - Expect HIT_CNT = 1 and IN_READY high again 2 edges after accept.
- **All codes.** Sweep the 8 table values 0x0000, 0x0001, 0x0020, 0x0040, 0x0060, 0xFFFF, 0x0090, 0x0009.
  - Expect OUT_CODE = 0..7 respectively, with latency k+1 edges (e.g. 0x0009 returns code 7 after 8 edges).
  - Expect HIT_CNT = 8 at the end.
- **Miss.** Present 0x1234.
  - Expect OUT_VALID after 8 edges, OUT_HIT = 0, OUT_CODE = 0, OUT_VALUE = 0x1234, MISS_CNT = 1.
- **Backpressure.** Encode 0xFFFF with OUT_READY held low for 5 cycles after OUT_VALID rises.
  - Expect OUT_CODE = 5, OUT_HIT = 1, OUT_VALUE = 0xFFFF stable throughout.
  - Expect IN_READY = 0, and a changing IN_VALUE to be ignored.
  - Raise OUT_READY: OUT_VALID drops on that edge.
- **Reset mid-operation.** Start 0x0090, then assert RST 3 edges after accept.
  - Expect every output at its reset value and IN_READY = 1.
  - Expect HIT_CNT unchanged at 0, and a following 0x0090 to return code 6 normally.
- **Saturation.** Run 260 misses with CNT_W = 8.
  - Expect MISS_CNT to stop at 255 and HIT_CNT = 0.
